// File: rtl/bus_master_burst.sv
// bus_master_burst
// Bit-serial bus master with configurable data/address width, multi-beat
// bursts, header ACK timeout with automatic retry, error reporting and bus
// parking. A local requester drives the M_* side; the shared serial bus
// (arbiter and slaves) sits on the B_* side.
//
// Ports
//   CLK, RSTN   : clock (rising edge) and synchronous active-low reset
//   M_ADDR      : start address, latched at transaction start
//   M_RW        : 1 = write, 0 = read, latched at start
//   M_BLEN      : beats minus one, latched at start
//   M_DIN       : write data (beat 0 at start, later beats in WLOAD)
//   M_EXECUTE   : start request (ignored while busy)
//   M_HOLD      : keep bus ownership after the transaction
//   M_DOUT      : last received read beat
//   M_DVALID    : pulse, read beat ready or write beat acknowledged
//   M_DREQ      : pulse, requester must present the next write beat
//   M_BSY       : transaction in progress
//   M_ERR       : pulse, retries exhausted, write ACK timeout or grant lost
//   B_REQ/B_GRANT : arbiter handshake
//   B_UTIL      : bus in use (header through last beat)
//   B_RW        : transaction direction while B_UTIL is high
//   B_ACK       : slave acknowledge
//   B_BUS_OUT/B_BUS_IN : serial data, MSB first
module bus_master_burst #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int BURST_MAX   = 4,
    parameter int ACK_TIMEOUT = 32,
    parameter int RETRY_MAX   = 2
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [ADDR_W-1:0]            M_ADDR,
    input  logic                         M_RW,
    input  logic [$clog2(BURST_MAX)-1:0] M_BLEN,
    input  logic [DATA_W-1:0]            M_DIN,
    input  logic                         M_EXECUTE,
    input  logic                         M_HOLD,
    output logic [DATA_W-1:0]            M_DOUT,
    output logic                         M_DVALID,
    output logic                         M_DREQ,
    output logic                         M_BSY,
    output logic                         M_ERR,
    output logic                         B_REQ,
    input  logic                         B_GRANT,
    output logic                         B_UTIL,
    output logic                         B_RW,
    input  logic                         B_ACK,
    output logic                         B_BUS_OUT,
    input  logic                         B_BUS_IN
);

    localparam int BL_W    = $clog2(BURST_MAX);
    localparam int HDR_W   = ADDR_W + BL_W;
    localparam int CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W   = $clog2(RETRY_MAX + 2);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);

    typedef enum logic [3:0] {
        IDLE, REQ, HDR, HACK, WDATA, WACK, WLOAD, RDATA, DONE, PARK
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [BL_W-1:0]   blen_q;
    logic [HDR_W-1:0]  hdr_sr;
    logic [DATA_W-1:0] wr_sr;
    logic [DATA_W-2:0] rd_sr;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] dout_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [RTY_W-1:0]  retry_cnt;
    logic [BL_W-1:0]   beat_cnt;
    logic              dvalid_q, dreq_q, err_q;

    logic start, retry, err_set, dvalid_set, dreq_set, beat_inc;
    logic last_beat, ack_timeout;

    assign last_beat   = (beat_cnt == blen_q);
    assign ack_timeout = (tmo_cnt == TMO_LAST);
    assign rd_next     = {rd_sr, B_BUS_IN};

    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_next;
    end

    // Grant loss is checked first in every bus-owning state so that an
    // arbiter revoke always wins over ACK or timeout on the same edge.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        retry      = 1'b0;
        err_set    = 1'b0;
        dvalid_set = 1'b0;
        dreq_set   = 1'b0;
        beat_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (M_EXECUTE) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (B_GRANT) state_next = HDR;
            end
            HDR: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (bit_cnt == HDR_LAST) begin
                    state_next = HACK;
                end
            end
            HACK: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (B_ACK) begin
                    state_next = rw_q ? WDATA : RDATA;
                end else if (ack_timeout) begin
                    if (retry_cnt < RTY_LIMIT) begin
                        retry      = 1'b1;
                        state_next = HDR;
                    end else begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WDATA: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (bit_cnt == DATA_LAST) begin
                    state_next = WACK;
                end
            end
            WACK: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (B_ACK) begin
                    dvalid_set = 1'b1;
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        dreq_set   = 1'b1;
                        beat_inc   = 1'b1;
                        state_next = WLOAD;
                    end
                end else if (ack_timeout) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            WLOAD: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WDATA;
                end
            end
            RDATA: begin
                if (!B_GRANT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (bit_cnt == DATA_LAST) begin
                    dvalid_set = 1'b1;
                    beat_inc   = 1'b1;
                    if (last_beat) state_next = DONE;
                end
            end
            DONE: begin
                state_next = M_HOLD ? PARK : IDLE;
            end
            PARK: begin
                if (M_EXECUTE) begin
                    start      = 1'b1;
                    state_next = B_GRANT ? HDR : REQ;
                end else if (!M_HOLD) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift registers, counters and the registered pulse outputs.
    // The header shifter is reloaded from the latched fields on each retry.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            addr_q    <= '0;
            rw_q      <= 1'b0;
            blen_q    <= '0;
            hdr_sr    <= '0;
            wr_sr     <= '0;
            rd_sr     <= '0;
            dout_q    <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            beat_cnt  <= '0;
            dvalid_q  <= 1'b0;
            dreq_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dvalid_q <= dvalid_set;
            dreq_q   <= dreq_set;
            err_q    <= err_set;

            if (state == HDR)
                bit_cnt <= (bit_cnt == HDR_LAST) ? '0 : bit_cnt + 1'b1;
            else if (state == WDATA || state == RDATA)
                bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
            else
                bit_cnt <= '0;

            if ((state == HACK || state == WACK) && !B_ACK)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;

            if (state == HDR)   hdr_sr <= {hdr_sr[HDR_W-2:0], 1'b0};
            if (state == WDATA) wr_sr  <= {wr_sr[DATA_W-2:0], 1'b0};
            if (state == WLOAD) wr_sr  <= M_DIN;

            if (state == RDATA) begin
                rd_sr <= rd_next[DATA_W-2:0];
                if (bit_cnt == DATA_LAST) dout_q <= rd_next;
            end

            if (beat_inc) beat_cnt <= beat_cnt + 1'b1;

            if (retry) begin
                retry_cnt <= retry_cnt + 1'b1;
                hdr_sr    <= {addr_q, blen_q};
            end

            if (start) begin
                addr_q    <= M_ADDR;
                rw_q      <= M_RW;
                blen_q    <= M_BLEN;
                hdr_sr    <= {M_ADDR, M_BLEN};
                wr_sr     <= M_DIN;
                beat_cnt  <= '0;
                retry_cnt <= '0;
                bit_cnt   <= '0;
                tmo_cnt   <= '0;
            end
        end
    end

    assign M_BSY     = !(state == IDLE || state == PARK);
    assign B_REQ     = (state != IDLE);
    assign B_UTIL    = (state == HDR) || (state == HACK) || (state == WDATA) ||
                       (state == WACK) || (state == WLOAD) || (state == RDATA);
    assign B_RW      = B_UTIL & rw_q;
    assign B_BUS_OUT = (state == HDR)   ? hdr_sr[HDR_W-1] :
                       (state == WDATA) ? wr_sr[DATA_W-1] : 1'b0;
    assign M_DOUT    = dout_q;
    assign M_DVALID  = dvalid_q;
    assign M_DREQ    = dreq_q;
    assign M_ERR     = err_q;

endmodule

// File: tb/tb_bus_master_burst.sv
// Testbench for bus_master_burst. A behavioural slave decodes headers and
// write beats from the serial line and streams read data back; a monitor
// pops expected beats from a scoreboard queue whenever M_DVALID pulses.
module tb_bus_master_burst;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int BL_W   = 2;
    localparam int HDR_W  = ADDR_W + BL_W;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic [ADDR_W-1:0] M_ADDR;
    logic              M_RW;
    logic [BL_W-1:0]   M_BLEN;
    logic [DATA_W-1:0] M_DIN;
    logic              M_EXECUTE, M_HOLD;
    logic [DATA_W-1:0] M_DOUT;
    logic              M_DVALID, M_DREQ, M_BSY, M_ERR;
    logic              B_REQ, B_GRANT, B_UTIL, B_RW, B_ACK, B_BUS_OUT, B_BUS_IN;

    bus_master_burst dut (
        .CLK(CLK), .RSTN(RSTN),
        .M_ADDR(M_ADDR), .M_RW(M_RW), .M_BLEN(M_BLEN), .M_DIN(M_DIN),
        .M_EXECUTE(M_EXECUTE), .M_HOLD(M_HOLD),
        .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_DREQ(M_DREQ),
        .M_BSY(M_BSY), .M_ERR(M_ERR),
        .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL), .B_RW(B_RW),
        .B_ACK(B_ACK), .B_BUS_OUT(B_BUS_OUT), .B_BUS_IN(B_BUS_IN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             rw;
        logic [HDR_W-1:0] hdr;
        int               nb;
        logic [31:0]      beats;
    } txn_t;

    typedef struct {
        logic       rw;
        logic [7:0] data;
    } beat_t;

    txn_t  slave_q[$];
    beat_t exp_q[$];
    beat_t mon_e;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int dreq_cnt = 0;
    int req_drop = 0;
    bit slave_en = 1'b0;
    bit grant_auto = 1'b0;
    bit watch_req = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {19'd0, M_DOUT, M_DVALID, M_DREQ, M_BSY, M_ERR, B_REQ, B_UTIL, B_RW, B_BUS_OUT};
    endfunction

    // Monitor: every M_DVALID consumes one scoreboard entry; read beats
    // are compared against the data the slave was told to return.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (M_ERR) err_cnt++;
            if (M_DREQ) dreq_cnt++;
            if (watch_req && !B_REQ) req_drop++;
            if (M_DVALID) begin
                if (exp_q.size() == 0) begin
                    checkOutput("dvalid_outstanding", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.rw) checkOutput("read_beat", M_DOUT, mon_e.data);
                end
            end
        end
    end

    // Arbiter model: grants after a random delay and holds the grant for as
    // long as the master keeps requesting.
    initial begin
        forever begin
            @(negedge CLK);
            if (grant_auto) begin
                if (!B_REQ) B_GRANT = 1'b0;
                else if (!B_GRANT && $urandom_range(0, 2) == 0) B_GRANT = 1'b1;
            end
        end
    end

    // Slave: called at the first header cycle, decodes everything on the
    // line by time position and answers with random ACK latencies.
    task automatic slaveTransaction();
        txn_t             t;
        logic [HDR_W-1:0] hdr;
        logic [7:0]       wb;
        int               d;
        hdr = '0;
        hdr = {hdr[HDR_W-2:0], B_BUS_OUT};
        for (int i = 1; i < HDR_W; i++) begin
            @(negedge CLK);
            hdr = {hdr[HDR_W-2:0], B_BUS_OUT};
        end
        if (slave_q.size() == 0) begin
            checkOutput("slave_txn_present", slave_q.size(), 1);
            return;
        end
        t = slave_q.pop_front();
        checkOutput("header", 32'(hdr), 32'(t.hdr));
        checkOutput("bus_rw", 32'(B_RW), 32'(t.rw));
        @(negedge CLK);
        d = $urandom_range(0, 6);
        repeat (d) @(negedge CLK);
        B_ACK = 1'b1;
        @(negedge CLK);
        B_ACK = 1'b0;
        if (!t.rw) begin
            for (int j = 0; j < t.nb; j++) begin
                for (int b = 7; b >= 0; b--) begin
                    B_BUS_IN = t.beats[j*8+b];
                    @(negedge CLK);
                end
            end
            B_BUS_IN = 1'b0;
        end else begin
            for (int j = 0; j < t.nb; j++) begin
                if (j > 0) @(negedge CLK);
                wb = '0;
                wb = {wb[6:0], B_BUS_OUT};
                for (int b = 1; b < 8; b++) begin
                    @(negedge CLK);
                    wb = {wb[6:0], B_BUS_OUT};
                end
                checkOutput("write_beat", 32'(wb), 32'(t.beats[j*8 +: 8]));
                @(negedge CLK);
                d = $urandom_range(0, 6);
                repeat (d) @(negedge CLK);
                B_ACK = 1'b1;
                @(negedge CLK);
                B_ACK = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (slave_en && B_UTIL) slaveTransaction();
        end
    end

    // One transaction: expectations go into the queues first, then the
    // request is issued and M_DREQ is answered with the next beat.
    task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr,
                                 input logic [BL_W-1:0] blen, input bit park_check);
        txn_t  t;
        beat_t e;
        int    wr_idx;
        int    n;
        int    dreq0;
        t.rw    = rw;
        t.hdr   = {addr, blen};
        t.nb    = int'(blen) + 1;
        t.beats = $urandom();
        slave_q.push_back(t);
        for (int j = 0; j < t.nb; j++) begin
            e.rw   = rw;
            e.data = t.beats[j*8 +: 8];
            exp_q.push_back(e);
        end
        dreq0 = dreq_cnt;
        @(negedge CLK);
        M_ADDR    = addr;
        M_RW      = rw;
        M_BLEN    = blen;
        M_DIN     = t.beats[7:0];
        M_EXECUTE = 1'b1;
        @(negedge CLK);
        M_EXECUTE = 1'b0;
        if (park_check) begin
            checkOutput("park_hdr_util", 32'(B_UTIL), 1);
            checkOutput("park_hdr_msb", 32'(B_BUS_OUT), 32'(addr[ADDR_W-1]));
        end
        wr_idx = 1;
        n = 0;
        while (M_BSY && n < 3000) begin
            if (M_DREQ && wr_idx < 4) begin
                M_DIN = t.beats[wr_idx*8 +: 8];
                wr_idx++;
            end
            @(negedge CLK);
            n++;
        end
        checkOutput("txn_complete", 32'(n < 3000), 1);
        checkOutput("dreq_count", 32'(dreq_cnt - dreq0), rw ? 32'(blen) : 32'd0);
        checkOutput("dvalid_count", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic waitUtil();
        int n;
        n = 0;
        while (!B_UTIL && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("header_started", 32'(B_UTIL), 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int err0;
        RSTN = 1'b0; M_ADDR = '0; M_RW = 1'b0; M_BLEN = '0; M_DIN = '0;
        M_EXECUTE = 1'b0; M_HOLD = 1'b0; B_GRANT = 1'b0; B_ACK = 1'b0; B_BUS_IN = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_outputs", allOutputs(), 0);
        RSTN = 1'b1;
        grant_auto = 1'b1;
        slave_en = 1'b1;

        $display("[TB] random transactions");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom_range(0, 3)), 1'b0);
        applyStimulus(1'b0, 16'hA5C3, 2'd3, 1'b0);
        checkOutput("no_err_random", 32'(err_cnt), 0);

        $display("[TB] reset during read data");
        slave_en = 1'b0;
        @(negedge CLK);
        M_ADDR = 16'h4321; M_RW = 1'b0; M_BLEN = 2'd1; M_EXECUTE = 1'b1;
        @(negedge CLK);
        M_EXECUTE = 1'b0;
        waitUtil();
        repeat (HDR_W) @(negedge CLK);
        B_ACK = 1'b1;
        @(negedge CLK);
        B_ACK = 1'b0;
        B_BUS_IN = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("pre_reset_util", 32'(B_UTIL), 1);
        RSTN = 1'b0;
        @(negedge CLK);
        checkOutput("reset1_outputs", allOutputs(), 0);
        @(negedge CLK);
        checkOutput("reset2_outputs", allOutputs(), 0);
        RSTN = 1'b1;
        B_BUS_IN = 1'b0;
        slave_en = 1'b1;
        applyStimulus(1'b0, 16'($urandom()), 2'd2, 1'b0);
        applyStimulus(1'b1, 16'($urandom()), 2'd3, 1'b0);

        $display("[TB] header ACK timeout");
        slave_en = 1'b0;
        err0 = err_cnt;
        @(negedge CLK);
        M_ADDR = 16'h8000 | 16'($urandom()); M_RW = 1'b1; M_BLEN = 2'd0; M_EXECUTE = 1'b1;
        @(negedge CLK);
        M_EXECUTE = 1'b0;
        waitUtil();
        for (int k = 1; k <= 150; k++) begin
            @(negedge CLK);
            if (k == 49 || k == 99) checkOutput("to_hack_line_idle", 32'(B_BUS_OUT), 0);
            if (k == 50 || k == 100) checkOutput("to_retry_msb", 32'(B_BUS_OUT), 1);
            if (k == 149) checkOutput("to_no_early_err", 32'(M_ERR), 0);
        end
        checkOutput("to_err_pulse", 32'(M_ERR), 1);
        checkOutput("to_breq_low", 32'(B_REQ), 0);
        @(negedge CLK);
        checkOutput("to_err_count", 32'(err_cnt - err0), 1);

        $display("[TB] grant loss during write");
        grant_auto = 1'b0;
        B_GRANT = 1'b1;
        @(negedge CLK);
        M_ADDR = 16'h1234; M_RW = 1'b1; M_BLEN = 2'd3; M_DIN = 8'h11; M_EXECUTE = 1'b1;
        @(negedge CLK);
        M_EXECUTE = 1'b0;
        waitUtil();
        repeat (HDR_W) @(negedge CLK);
        B_ACK = 1'b1;
        @(negedge CLK);
        B_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("gl_util_before", 32'(B_UTIL), 1);
        B_GRANT = 1'b0;
        @(negedge CLK);
        checkOutput("gl_err", 32'(M_ERR), 1);
        checkOutput("gl_util", 32'(B_UTIL), 0);
        checkOutput("gl_breq", 32'(B_REQ), 0);
        grant_auto = 1'b1;

        $display("[TB] parked back-to-back transactions");
        slave_en = 1'b1;
        M_HOLD = 1'b1;
        applyStimulus(1'b0, 16'($urandom()), 2'($urandom_range(0, 3)), 1'b0);
        checkOutput("park_breq", 32'(B_REQ), 1);
        watch_req = 1'b1;
        applyStimulus(1'b0, 16'($urandom()), 2'($urandom_range(0, 3)), 1'b1);
        applyStimulus(1'b1, 16'($urandom()), 2'($urandom_range(0, 3)), 1'b1);
        watch_req = 1'b0;
        checkOutput("park_req_never_fell", 32'(req_drop), 0);
        M_HOLD = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("unpark_breq", 32'(B_REQ), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_master_burst.md
# bus_master_burst

Parametrised bit-serial bus master, the successor to the existing single-byte serial master. It sits between a local requester (M_* side) and the shared serial bus arbiter/slaves (B_* side). It adds configurable data and address width, multi-beat bursts, an ACK timeout with automatic header retry, error reporting, and bus parking under M_HOLD.

## Interface
- DATA_W, 8: data beat width in bits.
- ADDR_W, 16: address width in bits.
- BURST_MAX, 4: maximum beats per transaction; must be a power of two ≥ 2. BL_W = $clog2(BURST_MAX).
- ACK_TIMEOUT, 32: consecutive cycles without B_ACK before a retry.
- RETRY_MAX, 2: number of header retries before an error.
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- M_ADDR  in  ADDR_W  start address, latched at start.
- M_RW  in  1  1 = write, 0 = read; latched at start.
- M_BLEN  in  BL_W  beats minus 1; latched at start.
- M_DIN  in  DATA_W  write data.
- M_EXECUTE  in  1  start request.
- M_HOLD  in  1  keep bus ownership after the transaction (parking).
- M_DOUT  out  DATA_W  last read beat.
- M_DVALID  out  1  one-cycle pulse: read beat in M_DOUT, or write beat acknowledged.
- M_DREQ  out  1  one-cycle pulse: supply the next write beat.
- M_BSY  out  1  high in every state except IDLE and PARK.
- M_ERR  out  1  one-cycle pulse: retries exhausted or grant lost.
- B_REQ  out  1  bus request to the arbiter.
- B_GRANT  in  1  bus grant.
- B_UTIL  out  1  bus in use; high from HDR through the last beat.
- B_RW  out  1  latched M_RW, driven while B_UTIL = 1, otherwise 0.
- B_ACK  in  1  slave acknowledge.
- B_BUS_OUT  out  1  serial data out, MSB first.
- B_BUS_IN  in  1  serial data in, MSB first.

## Operation
- States: IDLE, REQ, HDR, HACK, WDATA, WACK, WLOAD, RDATA, DONE, PARK.
- IDLE: M_EXECUTE=1 latches M_ADDR, M_RW, M_BLEN and M_DIN (beat 0), then goes to REQ.
- REQ: B_REQ=1. B_GRANT=1 moves to HDR.
- HDR: shifts {addr, blen}, HDR_W = ADDR_W+BL_W bits, MSB first, one bit per cycle, then goes to HACK.
- HACK: waits for B_ACK. On ACK, goes to WDATA (write) or RDATA (read).
  - Timeout: ACK_TIMEOUT consecutive cycles with ACK low. If the retry count < RETRY_MAX, increment it and return to HDR. Otherwise pulse M_ERR and go to IDLE.
- WDATA: shifts DATA_W bits, then goes to WACK. WACK uses the same timeout, but expiry is a direct error with no retry.
- WACK on ACK: pulse M_DVALID.
  - If this was the last beat, go to DONE.
  - Otherwise pulse M_DREQ and go to WLOAD. WLOAD samples M_DIN at its closing edge, then goes to WDATA.
- RDATA: samples B_BUS_IN on DATA_W consecutive edges.
  - After the last bit, M_DOUT is updated and M_DVALID pulses in the following cycle.
  - The next beat streams back-to-back with no re-ACK.
  - After the last beat, go to DONE.
- DONE (1 cycle): B_UTIL=0. M_HOLD=1 goes to PARK; M_HOLD=0 clears B_REQ and goes to IDLE.
- PARK: B_REQ stays 1.
  - M_EXECUTE=1 latches the inputs and goes directly to HDR if B_GRANT=1, otherwise to REQ.
  - M_HOLD=0 goes to IDLE.
- The beat counter and retry counter clear at every transaction start.

## Timing
- Reset (RSTN low at an edge): every output is 0, M_DOUT=0, all counters are 0, state is IDLE. This applies in every state, including mid-transaction.
- M_EXECUTE sampled at edge k: B_REQ=1 from edge k.
- B_GRANT sampled high in REQ at edge g: the header MSB is on B_BUS_OUT from edge g. The header LSB is driven during cycle g+HDR_W-1.
- B_BUS_OUT is 0 outside HDR and WDATA.
- B_ACK is sampled only in HACK and WACK; it is ignored elsewhere.
- Grant loss: B_GRANT=0 sampled in any state from HDR through RDATA causes an M_ERR pulse and a move to IDLE. B_UTIL and B_REQ are 0 from that edge.
- M_EXECUTE in a busy state is ignored.
- Timeout and ACK on the same edge: ACK wins.

## Test plan
- Reset mid-RDATA with RSTN=0 for 2 cycles -> all outputs 0, B_UTIL=0, M_DOUT=0. A fresh M_EXECUTE afterwards works.
- Single write, default parameters, addr 0x1234, M_DIN=0xAD, BLEN=0, grant immediate -> B_BUS_OUT emits 0001001000110100_00 over 18 cycles. After ACK, it emits 10101101. After ACK, M_DVALID pulses once.
- Read burst, BLEN=1: slave ACKs the header, then drives 0xB5, 0x3C on consecutive cycles -> M_DOUT=0xB5 with M_DVALID, and exactly 8 cycles later M_DOUT=0x3C with M_DVALID.
- No header ACK -> header sent 3 times, each 32 cycles after the previous header end. Then M_ERR pulses and B_REQ=0.
- Write burst of 4 beats with M_DIN 0x11, 0x22, 0x33, 0x44 supplied after each M_DREQ -> 4 bytes on the bus in order, 3 M_DREQ pulses, 4 M_DVALID pulses. Drop B_GRANT during beat 3 -> M_ERR pulses and B_UTIL=0 at the same edge.
- M_HOLD=1 with two back-to-back reads -> B_REQ never falls. The second header MSB appears the cycle after M_EXECUTE, with no REQ cycle.
